// File: rtl/p_emap_row_writer_if.sv
// ---------------------------------------------------------------------------
// p_emap_row_writer_if
//
// Groups the element stream and the P_Emap row write port of the row writer.
//
//   Element stream (producer -> writer)
//     in_valid      element present
//     in_ready      writer can take an element this cycle
//     in_col        column index, 24'hFFFFFF (zero-extended) marks "no column"
//     in_data       element value
//     in_last       final element of the vector
//   Row write port and status (writer -> memory / control)
//     write_enable  one-cycle row write strobe
//     write_address row address
//     input_data    packed row, lane 0 in the most significant slot
//     done          one-cycle pulse once the vector is fully written
//     err           sticky error flag
//
// Modports: master = element producer / memory side, slave = row writer.
// ---------------------------------------------------------------------------
interface p_emap_row_writer_if #(
  parameter int element_width        = 32,
  parameter int no_of_units          = 8,
  parameter int memory_height        = 1000,
  parameter int address_width        = $clog2(memory_height) + 1,
  parameter int col_nos_values_width = 32
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [col_nos_values_width-1:0]      in_col;
  logic [element_width-1:0]             in_data;
  logic                                 in_last;
  logic                                 write_enable;
  logic [address_width-1:0]             write_address;
  logic [no_of_units*element_width-1:0] input_data;
  logic                                 done;
  logic                                 err;

  modport master (
    output in_valid, in_col, in_data, in_last,
    input  in_ready, write_enable, write_address, input_data, done, err
  );

  modport slave (
    input  in_valid, in_col, in_data, in_last,
    output in_ready, write_enable, write_address, input_data, done, err
  );
endinterface

// File: rtl/p_emap_row_writer.sv
// ---------------------------------------------------------------------------
// p_emap_row_writer
//
// Scatter-side writer for the P_Emap vector memory. Takes (column, value)
// pairs in ascending column order, collects them into no_of_units-wide rows
// and writes each row once, with unwritten lanes as zero.
//
// Ports
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    p_emap_row_writer_if.slave: element stream in, row write port,
//          done pulse and sticky err out
//
// Optional feature (macro P_EMAP_WR_COUNT_EN):
//   rows_written    rows written so far in the current vector
//   last_row_count  rows written by the previous vector, captured on done
// ---------------------------------------------------------------------------
module p_emap_row_writer #(
  parameter int element_width        = 32,
  parameter int no_of_units          = 8,
  parameter int memory_height        = 1000,
  parameter int address_width        = $clog2(memory_height) + 1,
  parameter int col_nos_values_width = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  p_emap_row_writer_if.slave       bus
`ifdef P_EMAP_WR_COUNT_EN
  ,
  output logic [address_width-1:0] rows_written,
  output logic [address_width-1:0] last_row_count
`endif
);
  localparam int lane_bits = $clog2(no_of_units);
  localparam logic [col_nos_values_width-1:0] invalid_col = col_nos_values_width'(24'hFFFFFF);

  typedef enum logic [1:0] {ACCUM, FLUSH, DONE} state_t;

  state_t state_q, state_d;
  logic   ready_q;

  // Row buffer. Packed index no_of_units-1 is lane 0, so the buffer already
  // has the memory's row layout and can be written out unchanged.
  logic [no_of_units-1:0][element_width-1:0] buf_q, buf_d;
  logic [address_width-1:0]                  row_q, row_d;
  logic                                      nonempty_q, nonempty_d;

  logic                                 we_q, we_d;
  logic [address_width-1:0]             waddr_q, waddr_d;
  logic [no_of_units*element_width-1:0] wdata_q, wdata_d;
  logic                                 done_q;
  logic                                 err_q, err_d;

  logic                            accept;
  logic                            col_invalid;
  logic                            row_oob;
  logic                            row_change;
  logic [col_nos_values_width-1:0] in_row_full;
  logic [address_width-1:0]        in_row;
  logic [lane_bits-1:0]            in_lane;

  assign accept      = bus.in_valid && ready_q;
  assign col_invalid = (bus.in_col == invalid_col);
  assign in_row_full = bus.in_col >> lane_bits;
  assign in_lane     = bus.in_col[lane_bits-1:0];
  assign row_oob     = (in_row_full > col_nos_values_width'(memory_height));
  assign in_row      = in_row_full[address_width-1:0];

  // Element absorption and FSM. A row change emits the old row and loads the
  // new element in the same cycle, so the stream never stalls in ACCUM. When
  // the last element does not change rows, the absorbed buffer is written
  // straight away and FLUSH only waits one cycle before DONE; after a row
  // change on the last element, FLUSH writes the new row and then waits.
  // Packed index ~lane equals no_of_units-1-lane because no_of_units is a
  // power of two.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    buf_d      = buf_q;
    nonempty_d = nonempty_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    row_change = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (!col_invalid) begin
            if (row_oob) begin
              err_d = 1'b1;
            end else begin
              if (nonempty_q && (in_row != row_q)) begin
                row_change = 1'b1;
                we_d       = 1'b1;
                waddr_d    = row_q;
                wdata_d    = buf_q;
                buf_d      = '0;
                if (in_row < row_q) begin
                  err_d = 1'b1;
                end
              end
              row_d          = in_row;
              buf_d[~in_lane] = bus.in_data;
              nonempty_d     = 1'b1;
            end
          end
          if (bus.in_last) begin
            if (row_change) begin
              state_d = FLUSH;
            end else if (nonempty_d) begin
              we_d       = 1'b1;
              waddr_d    = row_d;
              wdata_d    = buf_d;
              buf_d      = '0;
              nonempty_d = 1'b0;
              row_d      = '0;
              state_d    = FLUSH;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      FLUSH: begin
        if (nonempty_q) begin
          we_d       = 1'b1;
          waddr_d    = row_q;
          wdata_d    = buf_q;
          buf_d      = '0;
          nonempty_d = 1'b0;
          row_d      = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d    = ACCUM;
        buf_d      = '0;
        nonempty_d = 1'b0;
        row_d      = '0;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // ready and done are registered from the next state so that ready stays low
  // throughout reset and both are clean flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      ready_q    <= 1'b0;
      buf_q      <= '0;
      row_q      <= '0;
      nonempty_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d == ACCUM);
      buf_q      <= buf_d;
      row_q      <= row_d;
      nonempty_q <= nonempty_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= (state_d == DONE);
      err_q      <= err_d;
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.write_enable  = we_q;
  assign bus.write_address = waddr_q;
  assign bus.input_data    = wdata_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

`ifdef P_EMAP_WR_COUNT_EN
  // Per-vector write counter; a write coinciding with done is still counted
  // into the captured total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_written   <= '0;
      last_row_count <= '0;
    end else if (done_q) begin
      last_row_count <= rows_written + address_width'(we_q);
      rows_written   <= '0;
    end else if (we_q) begin
      rows_written <= rows_written + address_width'(1);
    end
  end
`endif
endmodule

// File: tb/tb_p_emap_row_writer.sv
// ---------------------------------------------------------------------------
// tb_p_emap_row_writer
//
// Directed and randomized vectors for p_emap_row_writer. Each vector is sent
// back to back; observed row writes and done pulses are collected by a
// monitor and compared with a behavioural reference built from the
// column/row/lane rules.
// ---------------------------------------------------------------------------
module tb_p_emap_row_writer;
  typedef struct {
    logic [10:0]  addr;
    logic [255:0] data;
    int           cyc;
  } wr_t;

  typedef struct {
    logic [31:0] col;
    logic [31:0] data;
  } el_t;

  logic clk;
  logic rst_n;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   stallCount = 0;

  wr_t  gotQ[$];
  wr_t  expQ[$];
  int   doneQ[$];
  int   accQ[$];
  el_t  vecQ[$];

  p_emap_row_writer_if bus ();

`ifdef P_EMAP_WR_COUNT_EN
  logic [10:0] rows_written;
  logic [10:0] last_row_count;
`endif

  p_emap_row_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef P_EMAP_WR_COUNT_EN
    ,
    .rows_written   (rows_written),
    .last_row_count (last_row_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: cycle K lies between the K-th and (K+1)-th rising edges.
  always @(posedge clk) cycle <= cycle + 1;

  // Collect writes and done pulses in the middle of each cycle.
  always @(negedge clk) begin
    if (rst_n && bus.write_enable) gotQ.push_back('{addr: bus.write_address, data: bus.input_data, cyc: cycle});
    if (rst_n && bus.done) doneQ.push_back(cycle);
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] packLanes(input logic [31:0] l [8]);
    logic [255:0] p;
    p = '0;
    for (int r = 0; r < 8; r++) p = (p << 32) | 256'(l[r]);
    return p;
  endfunction

  // Drives one element and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] col, input logic [31:0] data, input logic last);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_col   = col;
    bus.in_data  = data;
    bus.in_last  = last;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    stallCount += waited;
    if (!bus.in_ready) begin
      checkOutput("ready_timeout", 256'(bus.in_ready), 256'(1));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    accQ.push_back(cycle - 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic resetDut();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference: row = col/8, lane = col%8; rows are emitted when the row
  // changes and once more at the end of the vector.
  task automatic buildExpected(output logic expErr, output int expDoneCyc);
    logic [31:0] lanes [8];
    int          curRow;
    int          row;
    int          lane;
    int          lastIdx;
    bit          lastChanged;
    expQ.delete();
    expErr      = 1'b0;
    curRow      = -1;
    lastChanged = 1'b0;
    lastIdx     = vecQ.size() - 1;
    for (int r = 0; r < 8; r++) lanes[r] = '0;
    for (int i = 0; i < vecQ.size(); i++) begin
      if (vecQ[i].col == 32'h00FFFFFF) continue;
      row  = int'(vecQ[i].col / 8);
      lane = int'(vecQ[i].col % 8);
      if (row > 1000) begin
        expErr = 1'b1;
        continue;
      end
      if (curRow >= 0 && row != curRow) begin
        if (row < curRow) expErr = 1'b1;
        expQ.push_back('{addr: 11'(curRow), data: packLanes(lanes), cyc: accQ[i] + 1});
        for (int r = 0; r < 8; r++) lanes[r] = '0;
        if (i == lastIdx) lastChanged = 1'b1;
      end
      curRow      = row;
      lanes[lane] = vecQ[i].data;
    end
    if (curRow >= 0) begin
      expQ.push_back('{addr: 11'(curRow), data: packLanes(lanes), cyc: accQ[lastIdx] + (lastChanged ? 2 : 1)});
      expDoneCyc = accQ[lastIdx] + (lastChanged ? 3 : 2);
    end else begin
      expDoneCyc = accQ[lastIdx] + 1;
    end
  endtask

  task automatic runVector(input string name);
    logic expErr;
    int   expDone;
    int   b2b;
    gotQ.delete();
    doneQ.delete();
    accQ.delete();
    stallCount = 0;
    for (int i = 0; i < vecQ.size(); i++) applyStimulus(vecQ[i].col, vecQ[i].data, (i == vecQ.size() - 1));
    checkOutput({name, ":ready_after_last"}, 256'(bus.in_ready), 256'(0));
    for (int k = 0; k < 30 && doneQ.size() == 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    buildExpected(expErr, expDone);
    checkOutput({name, ":stalls"}, 256'(stallCount), 256'(0));
    checkOutput({name, ":writes"}, 256'(gotQ.size()), 256'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checkOutput($sformatf("%s:addr%0d", name, i), 256'(gotQ[i].addr), 256'(expQ[i].addr));
      checkOutput($sformatf("%s:data%0d", name, i), gotQ[i].data, expQ[i].data);
      checkOutput($sformatf("%s:wcyc%0d", name, i), 256'(gotQ[i].cyc), 256'(expQ[i].cyc));
    end
    b2b = 0;
    for (int i = 1; i < gotQ.size(); i++)
      if (gotQ[i].cyc == gotQ[i-1].cyc + 1 && gotQ[i].addr == gotQ[i-1].addr) b2b++;
    checkOutput({name, ":same_addr_b2b"}, 256'(b2b), 256'(0));
    checkOutput({name, ":err"}, 256'(bus.err), 256'(expErr));
    checkOutput({name, ":done_count"}, 256'(doneQ.size()), 256'(1));
    checkOutput({name, ":done_cycle"}, 256'((doneQ.size() > 0) ? doneQ[0] : -1), 256'(expDone));
`ifdef P_EMAP_WR_COUNT_EN
    checkOutput({name, ":last_row_count"}, 256'(last_row_count), 256'(expQ.size()));
`endif
  endtask

  initial begin
    int len;
    int cur;
    int kind;
    logic [31:0] c;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_col   = '0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst:in_ready", 256'(bus.in_ready), 256'(0));
    checkOutput("rst:write_enable", 256'(bus.write_enable), 256'(0));
    checkOutput("rst:write_address", 256'(bus.write_address), 256'(0));
    checkOutput("rst:input_data", bus.input_data, 256'(0));
    checkOutput("rst:done", 256'(bus.done), 256'(0));
    checkOutput("rst:err", 256'(bus.err), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst:ready_after_release", 256'(bus.in_ready), 256'(1));

    // Full row 0
    vecQ.delete();
    for (int i = 0; i < 8; i++) vecQ.push_back('{col: 32'(i), data: 32'(i + 1)});
    runVector("full_row");
    if (gotQ.size() > 0)
      checkOutput("full_row:const", gotQ[0].data,
                  256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);

    // Sparse columns across three rows
    resetDut();
    vecQ = '{'{col: 32'd5, data: 32'hA}, '{col: 32'd9, data: 32'hB}, '{col: 32'd17, data: 32'hC}};
    runVector("sparse");

    // Only invalid columns
    resetDut();
    vecQ = '{'{col: 32'h00FFFFFF, data: 32'h1}, '{col: 32'h00FFFFFF, data: 32'h2}, '{col: 32'h00FFFFFF, data: 32'h3}};
    runVector("invalid_only");

    // Order violation
    resetDut();
    vecQ = '{'{col: 32'd16, data: 32'h16}, '{col: 32'd3, data: 32'h3}};
    runVector("order_violation");

    // Row beyond memory_height, then normal columns
    resetDut();
    vecQ = '{'{col: 32'd8008, data: 32'hDEAD}, '{col: 32'd0, data: 32'h11}, '{col: 32'd1, data: 32'h22}};
    runVector("row_oob");

    // Highest valid row
    resetDut();
    vecQ = '{'{col: 32'd8000, data: 32'h5A}, '{col: 32'd8007, data: 32'hA5}};
    runVector("top_row");

    // Reset in the middle of a row discards it
    resetDut();
    gotQ.delete();
    accQ.delete();
    for (int i = 0; i < 4; i++) applyStimulus(32'(i), 32'(i + 100), 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset:no_write", 256'(gotQ.size()), 256'(0));
    checkOutput("midreset:in_ready", 256'(bus.in_ready), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset:ready_after_release", 256'(bus.in_ready), 256'(1));
    vecQ = '{'{col: 32'd4, data: 32'h44}};
    runVector("midreset");

    // Randomized vectors; the final one starts near the top of the memory
    for (int v = 0; v < 12; v++) begin
      len = int'($urandom_range(1, 20));
      cur = (v == 11) ? 7990 : int'($urandom_range(0, 40));
      vecQ.delete();
      for (int i = 0; i < len; i++) begin
        kind = int'($urandom_range(0, 19));
        if (kind == 0) begin
          c = 32'h00FFFFFF;
        end else if (kind == 1) begin
          c = 32'd8008 + $urandom_range(0, 40);
        end else if (kind == 2) begin
          if (cur > 20) cur = cur - int'($urandom_range(8, 20));
          c = 32'(cur);
        end else begin
          cur = cur + int'($urandom_range(0, 6));
          c = 32'(cur);
        end
        vecQ.push_back('{col: c, data: $urandom});
      end
      resetDut();
      runVector($sformatf("rand%0d", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/p_emap_row_writer.md
# p_emap_row_writer

Scatter-side writer for the P_Emap vector memory. Accepts a stream of (column index, value) pairs in ascending column order, packs them into `no_of_units`-wide rows, and drives the memory's row write port (`write_enable`, `write_address`, `input_data`) one full row at a time. It sits between the solver datapath that produces vector results and the gather memory that later reads them by column.

## Interface
- `element_width`, 32: width of one vector element.
- `no_of_units`, 8: elements per memory row; power of two.
- `memory_height`, 1000: highest valid row address; rows 0..memory_height exist.
- `address_width`, $clog2(memory_height)+1: row address width.
- `col_nos_values_width`, 32: column index width.

- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: element present.
- `in_ready` out 1: element accepted when `in_valid && in_ready`.
- `in_col` in `col_nos_values_width`: column index; 24'hFFFFFF (zero-extended) = invalid.
- `in_data` in `element_width`: element value.
- `in_last` in 1: final element of the vector.
- `write_enable` out 1: one-cycle row write strobe.
- `write_address` out `address_width`: row address.
- `input_data` out `no_of_units*element_width`: packed row.
- `done` out 1: one-cycle pulse after the final row is written.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation
- row = `in_col / no_of_units`, lane = `in_col % no_of_units`. Use shift/mask, not a divider.
- Lane r occupies bits `[(no_of_units-r)*element_width-1 -: element_width]`, so lane 0 is the MSB slot.
- The row buffer holds the current row number, `no_of_units` lane registers, and a nonempty flag.
- Lanes never written in a row are written as zero.
- States:
  - ACCUM (`in_ready`=1)
  - FLUSH (`in_ready`=0)
  - DONE (`in_ready`=0)
- ACCUM, accepted valid element:
  - Same row as buffer, or buffer empty: write the lane and set nonempty.
  - Different row while nonempty: register the buffer as a write for the next cycle, clear the buffer, load the new element as the sole lane of the new row. No stall.
- Invalid column: consumed and discarded. `in_last` on it still applies.
- Row > `memory_height`: element dropped and `err` set.
- Row < current row (order violation): the current row is still flushed, the element starts a new row, and `err` is set.
- Same lane written twice in one row: last value wins. Not an error.
- `in_last` accepted → FLUSH.
  - If the buffer is nonempty after absorbing the last element, write it.
  - Then → DONE, which pulses `done` for one cycle and clears the buffer → ACCUM.
  - If the buffer is empty, the write is skipped.
- Reset mid-operation: the buffer and FSM clear and any pending write is discarded. The next cycle after release is ACCUM with `in_ready`=1.

## Timing
- Reset values:
  - `in_ready` 0 while `rst_n` is low, 1 from the first cycle after release.
  - `write_enable` 0, `write_address` 0, `input_data` 0, `done` 0, `err` 0.
- All outputs are registered.
- Row-change flush: accept at cycle N → `write_enable`=1 at N+1 with the previous row.
- `in_last` accepted at N:
  - A row change at N gives its write at N+1.
  - The final row is written at N+1 (no row change) or N+2 (row change).
  - `done` pulses the cycle after the final write, or at N+1 if nothing is written.
- `write_enable` is never high on two consecutive cycles for the same address.
- `input_data` and `write_address` are held stable only while `write_enable`=1.
- Throughput is one element per cycle in ACCUM. The per-vector overhead is at most 3 cycles of `in_ready`=0.

## Configuration
- `P_EMAP_WR_COUNT_EN` defined:
  - Adds output `rows_written`, `address_width` bits, reset 0.
  - Increments on every `write_enable` and clears when `done` pulses, after its value is captured into output `last_row_count`, also `address_width` bits, reset 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Cols 0..7 with data 1..8, `in_last` on col 7:
  - Exactly one write, address 0, `input_data`=0x00000001_00000002_…_00000008.
  - `done` one cycle after the write.
- Cols 5 (0xA), 9 (0xB), 17 (0xC) with `in_last`:
  - Writes to address 0 (lane 5=0xA, others 0), address 1 (lane 1=0xB), address 2 (lane 1=0xC).
  - `in_ready` stays high until `in_last` is accepted.
- Only invalid 0xFFFFFF columns, `in_last` on the third: no write, `done` pulses, `err`=0.
- Col 16 then col 3: row 2 written at the row change, row 0 written on flush, `err`=1.
- Col 8008, which is row 1001 > 1000: no write, `err`=1, subsequent valid columns written normally.
- Reset asserted mid-row after cols 0..3: no write occurs. After release, col 4 + `in_last` writes address 0 with only lane 4 nonzero.
